alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle ALU reference model used by the demo bench.
- Generic operand width, configurable pipeline depth, extended op set (shifts), status flags and illegal-op reporting.
- Valid/ready handshake on input and output, with full backpressure.
- Sits between the cocotb driver and the scoreboard as DUT and golden model for the demo ALU.

---
 rtl/alu_pkg.sv | 136 +++++++++++++
 rtl/alu_pipe_stage.sv | 40 ++++
 rtl/alu_pipe.sv | 68 ++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Op map, flag layout and the shared combinational compute for alu_pipe.
// Build option: define ALU_SAT_EN to make ops 12/13 signed saturating add/sub.
package alu_pkg;

  localparam int FLAG_W = 4;
  localparam int MAX_W  = 64;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_NOT   = 4'd2,
    OP_NAND  = 4'd3,
    OP_NOR   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SHL   = 4'd8,
    OP_SHR   = 4'd9,
    OP_SRA   = 4'd10,
    OP_PASS  = 4'd11,
    OP_SADD  = 4'd12,
    OP_SSUB  = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    word_t  r;
    flags_t flags;
    logic   err;
  } result_t;

  function automatic logic is_legal_op(op_e op);
`ifdef ALU_SAT_EN
    return op <= OP_SSUB;
`else
    return op <= OP_PASS;
`endif
  endfunction

  // Operands arrive zero-extended to MAX_W; width (a power of 2) selects the
  // active low bits, so one function serves every instantiated WIDTH.
  function automatic result_t alu_compute(op_e op, word_t a, word_t b, int unsigned width);
    result_t        res;
    word_t          mask;
    word_t          am;
    word_t          bm;
    word_t          ax;
    logic [MAX_W:0] sum;
    logic [MAX_W:0] dif;
    logic [5:0]     msb;
    logic [5:0]     sh;
    logic           add_v;
    logic           sub_v;
`ifdef ALU_SAT_EN
    word_t          smax;
    word_t          smin;
`endif
    res   = '0;
    msb   = 6'(width - 1);
    mask  = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
    am    = a & mask;
    bm    = b & mask;
    sh    = bm[5:0] & msb;
    ax    = am[msb] ? (am | ~mask) : am;
    sum   = {1'b0, am} + {1'b0, bm};
    dif   = {1'b0, am} - {1'b0, bm};
    add_v = (am[msb] == bm[msb]) && (sum[msb] != am[msb]);
    sub_v = (am[msb] != bm[msb]) && (dif[msb] != am[msb]);
`ifdef ALU_SAT_EN
    smax  = mask >> 1;
    smin  = mask ^ smax;
`endif
    if (!is_legal_op(op)) begin
      res.err = 1'b1;
    end else begin
      case (op)
        OP_ADD: begin
          res.r       = sum[MAX_W-1:0] & mask;
          res.flags.c = sum[7'(width)];
          res.flags.v = add_v;
        end
        OP_SUB: begin
          res.r       = dif[MAX_W-1:0] & mask;
          res.flags.c = am < bm;
          res.flags.v = sub_v;
        end
        OP_NOT:  res.r = ~am & mask;
        OP_NAND: res.r = ~(am & bm) & mask;
        OP_NOR:  res.r = ~(am | bm) & mask;
        OP_AND:  res.r = am & bm;
        OP_OR:   res.r = am | bm;
        OP_XOR:  res.r = am ^ bm;
        OP_SHL: begin
          res.r       = (am << sh) & mask;
          res.flags.c = (sh != 6'd0) && am[msb - sh + 6'd1];
        end
        OP_SHR: begin
          res.r       = am >> sh;
          res.flags.c = (sh != 6'd0) && am[sh - 6'd1];
        end
        OP_SRA: begin
          res.r       = word_t'($signed(ax) >>> sh) & mask;
          res.flags.c = (sh != 6'd0) && ax[sh - 6'd1];
        end
        OP_PASS: res.r = bm;
`ifdef ALU_SAT_EN
        OP_SADD: begin
          res.r       = add_v ? (am[msb] ? smin : smax) : (sum[MAX_W-1:0] & mask);
          res.flags.c = sum[7'(width)];
          res.flags.v = add_v;
        end
        OP_SSUB: begin
          res.r       = sub_v ? (am[msb] ? smin : smax) : (dif[MAX_W-1:0] & mask);
          res.flags.c = am < bm;
          res.flags.v = sub_v;
        end
`endif
        default: res.r = '0;
      endcase
      res.flags.z = (res.r == '0);
      res.flags.n = res.r[msb];
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice carrying {r, flags, err}; holds its contents
// while downstream stalls and accepts whenever it is empty or draining.
module alu_pipe_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_r,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic              in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  r,
  output logic [FLAG_W-1:0] flags,
  output logic              err
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      flags     <= '0;
      err       <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        r     <= in_r;
        flags <= in_flags;
        err   <= in_err;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational compute into a chain of STAGES register slices
// with full valid/ready backpressure. Ops 12/13 depend on ALU_SAT_EN (see alu_pkg).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [OP_W-1:0]   op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  r,
  output logic [FLAG_W-1:0] flags,
  output logic              err
);

  result_t res;
  logic    unused_r;

  wire [STAGES:0]     v_chain;
  wire [STAGES:0]     rdy_chain;
  wire [STAGES:0]     e_chain;
  wire [WIDTH-1:0]    r_chain [0:STAGES];
  wire [FLAG_W-1:0]   f_chain [0:STAGES];

  always_comb res = alu_compute(op_e'(op), word_t'(a), word_t'(b), WIDTH);

  // Bits above WIDTH are always zero from alu_compute.
  assign unused_r = &{1'b0, res.r};

  assign v_chain[0]        = in_valid;
  assign r_chain[0]        = res.r[WIDTH-1:0];
  assign f_chain[0]        = res.flags;
  assign e_chain[0]        = res.err;
  assign rdy_chain[STAGES] = out_ready;

  assign in_ready = !rst && rdy_chain[0];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    alu_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (v_chain[i]),
      .in_ready  (rdy_chain[i]),
      .in_r      (r_chain[i]),
      .in_flags  (f_chain[i]),
      .in_err    (e_chain[i]),
      .out_valid (v_chain[i+1]),
      .out_ready (rdy_chain[i+1]),
      .r         (r_chain[i+1]),
      .flags     (f_chain[i+1]),
      .err       (e_chain[i+1])
    );
  end

  assign out_valid = v_chain[STAGES];
  assign r         = r_chain[STAGES];
  assign flags     = f_chain[STAGES];
  assign err       = e_chain[STAGES];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32, STAGES=2): directed vectors with
// hand-computed results; a negedge monitor pops and checks every output beat.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int ST = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_NAND = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_PASS = 4'd11;
  localparam logic [3:0] OP_SADD = 4'd12;
  localparam logic [3:0] OP_SSUB = 4'd13;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic [3:0]   flags;
  logic         err;

  alu_pipe #(.WIDTH(W), .STAGES(ST), .OP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .flags     (flags),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic [3:0]   f;
    logic         e;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         sb_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc   = 0;
  bit           prev_hold = 1'b0;
  bit           head_seen = 1'b0;
  int           first_cyc = 0;
  logic [W-1:0] prev_r;
  logic [3:0]   prev_f;
  logic         prev_e;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: samples mid-cycle, so what it sees is what the next rising edge uses.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      prev_hold = 1'b0;
      head_seen = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", W'(out_valid), W'(1));
        check("hold_r", r, prev_r);
        check("hold_flags", W'(flags), W'(prev_f));
        check("hold_err", W'(err), W'(prev_e));
      end
      if (out_valid) begin
        if (!head_seen) begin
          head_seen = 1'b1;
          first_cyc = cyc;
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got r=%0h with empty scoreboard (cycle %0d)", r, cyc);
          end else begin
            e = sb_q.pop_front();
            check("result_r", r, e.r);
            check("result_flags", W'(flags), W'(e.f));
            check("result_err", W'(err), W'(e.e));
            if (e.lat) check("latency", W'(first_cyc - e.acc), W'(ST));
          end
          head_seen = 1'b0;
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_r    = r;
      prev_f    = flags;
      prev_e    = err;
    end
  end

  // Called just after a rising edge; returns just after the rising edge that
  // took the operation (or after the cycle budget runs out).
  task automatic send(input logic [3:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [W-1:0] er, input logic [3:0] ef, input logic ee, input bit lat);
    exp_t e;
    bit   accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      #1;
      if (in_ready) begin
        e.r = er; e.f = ef; e.e = ee; e.acc = cyc; e.lat = lat;
        sb_q.push_back(e);
        n_vec++;
        accepted = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for 100 cycles, expected acceptance of op %0d", o);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(0));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_r", r, W'(0));
    check("rst_flags", W'(flags), W'(0));
    check("rst_err", W'(err), W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("release_in_ready", W'(in_ready), W'(1));

    // Back-to-back directed vectors, flags written as {N,Z,C,V}.
    send(OP_ADD,  32'hFFFF_FFFF, 32'h1,  32'h0,         4'b0110, 1'b0, 1'b1);
    send(OP_SUB,  32'h8000_0000, 32'h1,  32'h7FFF_FFFF, 4'b0001, 1'b0, 1'b1);
    send(OP_SUB,  32'h1,         32'h2,  32'hFFFF_FFFF, 4'b1010, 1'b0, 1'b1);
    send(OP_SRA,  32'h8000_0010, 32'h5,  32'hFC00_0000, 4'b1010, 1'b0, 1'b1);
    send(OP_SHL,  32'h1,         32'h1F, 32'h8000_0000, 4'b1000, 1'b0, 1'b1);
    send(OP_SHR,  32'h18,        32'h4,  32'h1,         4'b0010, 1'b0, 1'b1);
    send(OP_SHL,  32'h5,         32'h20, 32'h5,         4'b0000, 1'b0, 1'b1);
    send(OP_ADD,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000, 4'b1001, 1'b0, 1'b1);
    send(OP_AND,  32'hF0F0,      32'hFF00, 32'hF000,    4'b0000, 1'b0, 1'b1);
    send(OP_OR,   32'hF0,        32'h0F, 32'hFF,        4'b0000, 1'b0, 1'b1);
    send(OP_XOR,  32'hFF,        32'hFF, 32'h0,         4'b0100, 1'b0, 1'b1);
    send(OP_NOT,  32'h0,         32'h0,  32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b1);
    send(OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,  4'b0100, 1'b0, 1'b1);
    send(OP_NOR,  32'h0,         32'h0,  32'hFFFF_FFFF, 4'b1000, 1'b0, 1'b1);
    send(OP_PASS, 32'hDEAD,      32'h1234, 32'h1234,    4'b0000, 1'b0, 1'b1);
    send(4'd14,   32'h5,         32'h5,  32'h0,         4'b0000, 1'b1, 1'b1);
    send(4'd15,   32'h5,         32'h5,  32'h0,         4'b0000, 1'b1, 1'b1);
`ifdef ALU_SAT_EN
    send(OP_SADD, 32'h7FFF_FFFF, 32'h1,  32'h7FFF_FFFF, 4'b0001, 1'b0, 1'b1);
    send(OP_SSUB, 32'h8000_0000, 32'h1,  32'h8000_0000, 4'b1001, 1'b0, 1'b1);
`else
    send(OP_SADD, 32'h7FFF_FFFF, 32'h1,  32'h0,         4'b0000, 1'b1, 1'b1);
    send(OP_SSUB, 32'h8000_0000, 32'h1,  32'h0,         4'b0000, 1'b1, 1'b1);
`endif
    drain();

    // Backpressure: two entries fill the pipe, the third must wait.
    out_ready = 1'b0;
    send(OP_ADD, 32'd0, 32'd1, 32'd1, 4'b0000, 1'b0, 1'b0);
    send(OP_ADD, 32'd1, 32'd1, 32'd2, 4'b0000, 1'b0, 1'b0);
    in_valid = 1'b1;
    op       = OP_ADD;
    a        = 32'd2;
    b        = 32'd1;
    repeat (3) begin
      @(negedge clk);
      #1 check("full_in_ready", W'(in_ready), W'(0));
      check("full_out_valid", W'(out_valid), W'(1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(OP_ADD, 32'd2, 32'd1, 32'd3, 4'b0000, 1'b0, 1'b0);
    send(OP_ADD, 32'd3, 32'd1, 32'd4, 4'b0000, 1'b0, 1'b0);
    drain();

    // Reset with two operations in flight: they must vanish.
    out_ready = 1'b0;
    send(OP_ADD, 32'd10, 32'd1, 32'd11, 4'b0000, 1'b0, 1'b0);
    send(OP_ADD, 32'd20, 32'd1, 32'd21, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_in_ready", W'(in_ready), W'(0));
    check("midrst_r", r, W'(0));
    check("midrst_err", W'(err), W'(0));
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("midrst_release_in_ready", W'(in_ready), W'(1));
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    send(OP_AND, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000, 1'b0, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
